// File: rtl/tbird_lamp_monitor.sv
// tbird_lamp_monitor: observes the T-bird tail-light bulbs on each TICK,
// tracks each side's lamp sequence and decodes the driver command.
// Ports: CLK100MHZ, RST (async, active high), TICK (sample strobe),
//   BULB_L/BULB_R {x3,x2,x1} lamps, MODE (decoded command), MODE_STB (pulse
//   one cycle after each sample), FAULT/FAULT_SIDE {left,right} sticky,
//   CYC_L/CYC_R saturating completed-ramp counters.
// Optional: define TBIRD_MON_SKEW_CHECK_EN to fault when both sides are
//   turning but show different bulb patterns.
module tbird_lamp_monitor #(
    parameter int IDLE_TO = 4,
    parameter int CNT_W   = 8
) (
    input  logic             CLK100MHZ,
    input  logic             RST,
    input  logic             TICK,
    input  logic [2:0]       BULB_L,
    input  logic [2:0]       BULB_R,
    output logic [2:0]       MODE,
    output logic             MODE_STB,
    output logic             FAULT,
    output logic [1:0]       FAULT_SIDE,
    output logic [CNT_W-1:0] CYC_L,
    output logic [CNT_W-1:0] CYC_R
);

    typedef enum logic [2:0] {
        S_IDLE, S_R1, S_R2, S_R3, S_ON, S_FLT
    } side_st_t;

    localparam logic [3:0] IDLE_LIM = 4'(IDLE_TO);

    // Index 1 is the left side, index 0 the right side.
    side_st_t         st         [2];
    side_st_t         st_n       [2];
    logic [3:0]       idle_cnt   [2];
    logic [3:0]       idle_cnt_n [2];
    logic [1:0]       on_cnt     [2];
    logic [1:0]       on_cnt_n   [2];
    logic [CNT_W-1:0] cyc        [2];
    logic [CNT_W-1:0] cyc_n      [2];
    logic [2:0]       bulb       [2];
    logic [1:0]       turn, turn_n;
    logic [1:0]       done;
    logic [1:0]       t_cls, n_cls;
    logic [2:0]       mode_n, dec;
    logic [1:0]       fside_n;

    always_ff @(posedge CLK100MHZ or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 2; i++) begin
                st[i]       <= S_IDLE;
                idle_cnt[i] <= '0;
                on_cnt[i]   <= '0;
                cyc[i]      <= '0;
            end
            turn       <= '0;
            MODE       <= '0;
            MODE_STB   <= 1'b0;
            FAULT      <= 1'b0;
            FAULT_SIDE <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                st[i]       <= st_n[i];
                idle_cnt[i] <= idle_cnt_n[i];
                on_cnt[i]   <= on_cnt_n[i];
                cyc[i]      <= cyc_n[i];
            end
            turn       <= turn_n;
            MODE       <= mode_n;
            MODE_STB   <= TICK;
            FAULT      <= |fside_n;
            FAULT_SIDE <= fside_n;
        end
    end

    always_comb begin
        bulb[1] = BULB_L;
        bulb[0] = BULB_R;
        turn_n  = turn;
        done    = '0;
        for (int i = 0; i < 2; i++) begin
            st_n[i]       = st[i];
            idle_cnt_n[i] = idle_cnt[i];
            on_cnt_n[i]   = on_cnt[i];
            cyc_n[i]      = cyc[i];
        end

        if (TICK) begin
            for (int i = 0; i < 2; i++) begin
                st_n[i] = S_FLT;
                case (st[i])
                    S_IDLE: begin
                        if (bulb[i] == 3'b000)
                            st_n[i] = S_IDLE;
                        else if (bulb[i] == 3'b001)
                            st_n[i] = S_R1;
                        else if (bulb[i] == 3'b111)
                            st_n[i] = S_ON;
                    end
                    S_R1: begin
                        if (bulb[i] == 3'b011)
                            st_n[i] = S_R2;
                        else if (bulb[i] == 3'b000)
                            st_n[i] = S_IDLE;
                    end
                    S_R2: begin
                        if (bulb[i] == 3'b111)
                            st_n[i] = S_R3;
                        else if (bulb[i] == 3'b000)
                            st_n[i] = S_IDLE;
                    end
                    S_R3: begin
                        if (bulb[i] == 3'b000)
                            st_n[i] = S_IDLE;
                        else if (bulb[i] == 3'b111)
                            st_n[i] = S_ON;
                    end
                    S_ON: begin
                        if (bulb[i] == 3'b111)
                            st_n[i] = S_ON;
                        else if (bulb[i] == 3'b000)
                            st_n[i] = S_IDLE;
                        else if (bulb[i] == 3'b001)
                            st_n[i] = S_R1;
                    end
                    default: st_n[i] = S_FLT;
                endcase

                done[i] = (st[i] == S_R3) && (bulb[i] == 3'b000);
                if (done[i]) begin
                    turn_n[i] = 1'b1;
                    if (cyc[i] != '1)
                        cyc_n[i] = cyc[i] + CNT_W'(1);
                end

                // The completing sample restarts the idle timeout.
                if (st_n[i] == S_IDLE && !done[i])
                    idle_cnt_n[i] = (idle_cnt[i] == 4'hF) ?
                                    4'hF : idle_cnt[i] + 4'd1;
                else
                    idle_cnt_n[i] = '0;

                if (st_n[i] == S_ON)
                    on_cnt_n[i] = (on_cnt[i] == 2'd2) ?
                                  2'd2 : on_cnt[i] + 2'd1;
                else
                    on_cnt_n[i] = '0;

                if (idle_cnt_n[i] == IDLE_LIM ||
                    on_cnt_n[i] == 2'd2 ||
                    st_n[i] == S_FLT)
                    turn_n[i] = 1'b0;
            end

`ifdef TBIRD_MON_SKEW_CHECK_EN
            // Hazard flashing must be in lock-step on both sides.
            if (turn_n == 2'b11 && BULB_L != BULB_R) begin
                st_n[1] = S_FLT;
                st_n[0] = S_FLT;
                turn_n  = 2'b00;
            end
`endif
        end

        fside_n = FAULT_SIDE |
                  {st_n[1] == S_FLT, st_n[0] == S_FLT};

        for (int i = 0; i < 2; i++) begin
            t_cls[i] = turn_n[i];
            n_cls[i] = (st_n[i] == S_ON) && !turn_n[i];
        end

        if (fside_n[1] || fside_n[0])
            dec = 3'd7;
        else if (t_cls[1] && t_cls[0])
            dec = 3'd4;
        else if (t_cls[1] && n_cls[0])
            dec = 3'd5;
        else if (t_cls[1])
            dec = 3'd1;
        else if (n_cls[1] && t_cls[0])
            dec = 3'd6;
        else if (t_cls[0])
            dec = 3'd2;
        else if (n_cls[1] && n_cls[0])
            dec = 3'd3;
        else
            dec = 3'd0;

        mode_n = TICK ? dec : MODE;
    end

    assign CYC_L = cyc[1];
    assign CYC_R = cyc[0];

endmodule

// File: tb/tb_tbird_lamp_monitor.sv
// Self-checking bench for tbird_lamp_monitor: expected results are queued
// per sample and compared when MODE_STB reports the update.
module tb_tbird_lamp_monitor;

    localparam int CW = 3;
    localparam int MX = 7;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tick = 1'b0;
    logic [2:0]    bl = '0;
    logic [2:0]    br = '0;
    logic [2:0]    mode;
    logic          mode_stb;
    logic          fault;
    logic [1:0]    fside;
    logic [CW-1:0] cyc_l, cyc_r;

    tbird_lamp_monitor #(.IDLE_TO(4), .CNT_W(CW)) dut (
        .CLK100MHZ (clk),
        .RST       (rst),
        .TICK      (tick),
        .BULB_L    (bl),
        .BULB_R    (br),
        .MODE      (mode),
        .MODE_STB  (mode_stb),
        .FAULT     (fault),
        .FAULT_SIDE(fside),
        .CYC_L     (cyc_l),
        .CYC_R     (cyc_r)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]    m;
        logic          f;
        logic [1:0]    fs;
        logic [CW-1:0] cl;
        logic [CW-1:0] cr;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int n_chk = 0, n_pass = 0, n_push = 0, n_stb = 0;
    logic          e_f  = 1'b0;
    logic [1:0]    e_fs = '0;
    logic [CW-1:0] e_cl = '0;
    logic [CW-1:0] e_cr = '0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // One sample on one clock; the inputs are scrambled while TICK=0.
    task automatic smp(input logic [2:0] l, input logic [2:0] r,
                       input logic [2:0] m);
        q.push_back('{m, e_f, e_fs, e_cl, e_cr});
        n_push++;
        tick = 1'b1;
        bl   = l;
        br   = r;
        @(negedge clk);
        tick = 1'b0;
        bl   = 3'($urandom_range(7));
        br   = 3'($urandom_range(7));
    endtask

    task automatic do_rst();
        #2;
        chk("q_empty", q.size(), 0);
        rst = 1'b1;
        #1;
        chk("rst_mode", mode, 0);
        chk("rst_stb", mode_stb, 0);
        chk("rst_fault", fault, 0);
        chk("rst_fside", fside, 0);
        chk("rst_cyc_l", cyc_l, 0);
        chk("rst_cyc_r", cyc_r, 0);
        e_f  = 1'b0;
        e_fs = '0;
        e_cl = '0;
        e_cr = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mode_stb) begin
            n_stb++;
            if (q.size() == 0) begin
                chk("stb_extra", 1, 0);
            end else begin
                e = q.pop_front();
                chk("mode", mode, e.m);
                chk("fault", fault, e.f);
                chk("fside", fside, e.fs);
                chk("cyc_l", cyc_l, e.cl);
                chk("cyc_r", cyc_r, e.cr);
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("por_mode", mode, 0);
        chk("por_stb", mode_stb, 0);
        chk("por_fault", fault, 0);
        chk("por_fside", fside, 0);
        chk("por_cyc_l", cyc_l, 0);
        chk("por_cyc_r", cyc_r, 0);
        rst = 1'b0;
        @(negedge clk);

        smp(3'b000, 3'b000, 0);

        // Left ramp, then idle timeout.
        smp(3'b001, 3'b000, 0);
        smp(3'b011, 3'b000, 0);
        smp(3'b111, 3'b000, 0);
        e_cl = 1;
        smp(3'b000, 3'b000, 1);
        smp(3'b000, 3'b000, 1);
        smp(3'b000, 3'b000, 1);
        smp(3'b000, 3'b000, 1);
        smp(3'b000, 3'b000, 0);
        repeat (3) @(negedge clk);

        // Left turn with right brake held, then brake clearing TURN.
        smp(3'b000, 3'b111, 0);
        smp(3'b001, 3'b111, 0);
        smp(3'b011, 3'b111, 0);
        smp(3'b111, 3'b111, 0);
        e_cl = 2;
        smp(3'b000, 3'b111, 5);
        smp(3'b000, 3'b000, 1);
        smp(3'b111, 3'b111, 5);
        smp(3'b111, 3'b111, 3);
        repeat (4) smp(3'b000, 3'b000, 0);

        // Right ramp, left brake while right still turning.
        smp(3'b000, 3'b001, 0);
        smp(3'b000, 3'b011, 0);
        smp(3'b000, 3'b111, 0);
        e_cr = 1;
        smp(3'b000, 3'b000, 2);
        smp(3'b111, 3'b000, 6);
        smp(3'b000, 3'b000, 2);
        smp(3'b000, 3'b000, 2);
        smp(3'b000, 3'b000, 0);

        // Hazard, then one-sample skew.
        smp(3'b001, 3'b001, 0);
        smp(3'b011, 3'b011, 0);
        smp(3'b111, 3'b111, 0);
        e_cl = 3;
        e_cr = 2;
        smp(3'b000, 3'b000, 4);
`ifdef TBIRD_MON_SKEW_CHECK_EN
        e_f  = 1'b1;
        e_fs = 2'b11;
        smp(3'b001, 3'b000, 7);
`else
        smp(3'b001, 3'b000, 4);
`endif

        // Reset while the left side is mid-ramp.
        do_rst();
        smp(3'b000, 3'b000, 0);

        // Illegal left pattern is sticky.
        e_f  = 1'b1;
        e_fs = 2'b10;
        smp(3'b010, 3'b000, 7);
        smp(3'b000, 3'b000, 7);
        smp(3'b001, 3'b000, 7);
        smp(3'b011, 3'b000, 7);
        smp(3'b111, 3'b000, 7);
        smp(3'b000, 3'b000, 7);
        do_rst();

        // 011 straight from idle on the right.
        e_f  = 1'b1;
        e_fs = 2'b01;
        smp(3'b000, 3'b011, 7);
        do_rst();

        // Counter saturation.
        for (int k = 0; k < MX + 2; k++) begin
            smp(3'b001, 3'b000, (k > 0) ? 3'd1 : 3'd0);
            smp(3'b011, 3'b000, (k > 0) ? 3'd1 : 3'd0);
            smp(3'b111, 3'b000, (k > 0) ? 3'd1 : 3'd0);
            e_cl = CW'((k + 1 > MX) ? MX : k + 1);
            smp(3'b000, 3'b000, 1);
        end

        repeat (3) @(negedge clk);
        chk("stb_cnt", n_stb, n_push);
        chk("q_left", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/tbird_lamp_monitor.md
# tbird_lamp_monitor

Observer for the T-bird tail-light block. It samples the six bulb outputs on each slow-clock strobe and tracks each side's lamp sequence with a per-side state machine. From those sequences it decodes the active driver command: idle, left, right, brake, hazard, turn-plus-brake, or fault. It sits beside the light controller on the board and feeds the LED/debug path and the self-check bench.

## Interface
- IDLE_TO, 4: consecutive IDLE samples that clear a side's TURN flag (range 2..15).
- CNT_W, 8: width of the completed-ramp counters.
- CLK100MHZ  in  1  system clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- TICK  in  1  one-cycle sample strobe from the divider; samples are taken only when TICK=1.
- BULB_L  in  3  left lamps {L3,L2,L1}.
- BULB_R  in  3  right lamps {R3,R2,R1}.
- MODE  out  3  decoded mode. 0 IDLE, 1 LEFT, 2 RIGHT, 3 BRAKE, 4 HAZARD, 5 LEFT_BRAKE, 6 RIGHT_BRAKE, 7 FAULT.
- MODE_STB  out  1  one-cycle pulse; MODE was updated on the previous edge.
- FAULT  out  1  sticky fault flag.
- FAULT_SIDE  out  2  {left,right}; sticky, shows which side(s) faulted.
- CYC_L, CYC_R  out  CNT_W  completed-ramp counts; saturate at all-ones.

## Operation
- Legal per-side patterns: 000, 001, 011, 111. Any other pattern drives that side to FLT.
- Per-side FSM states: IDLE, R1, R2, R3, ON, FLT. Transitions are evaluated only when TICK=1:
  - IDLE: 000 stays IDLE; 001 goes to R1; 111 goes to ON; 011 goes to FLT.
  - R1: 011 goes to R2; 000 goes to IDLE (abort, no count); anything else goes to FLT.
  - R2: 111 goes to R3; 000 goes to IDLE (abort, no count); anything else goes to FLT.
  - R3: 000 goes to IDLE and counts as a completed ramp; 111 goes to ON; 001 or 011 goes to FLT.
  - ON: 111 stays ON; 000 goes to IDLE; 001 goes to R1; 011 goes to FLT.
  - FLT: absorbing. Only RST leaves it.
- Completed ramp (R3 to IDLE): increments that side's CYC counter (saturating) and sets TURN.
- TURN flag clears on any of:
  - IDLE_TO consecutive samples in IDLE (4-bit idle counter, reset on any non-IDLE sample);
  - 2 consecutive samples in ON;
  - entry to FLT.
- Side class, computed after the sample update:
  - T if TURN=1;
  - N if state=ON and TURN=0;
  - O otherwise.
- MODE decode, first match wins:
  - either side in FLT: 7;
  - T/T: 4;
  - T/N: 5;
  - T/O: 1;
  - N/T: 6;
  - O/T: 2;
  - N/N: 3;
  - anything else: 0.
- FAULT and FAULT_SIDE set together with the FLT entry. Both hold until RST.

## Timing
- Reset values: every output is 0 (MODE=IDLE, MODE_STB=0, FAULT=0, FAULT_SIDE=00, CYC_L=CYC_R=0). Both FSMs are in IDLE and TURN, idle and ON counters are cleared.
- RST asserted mid-ramp returns everything to the reset values immediately, without waiting for a clock edge.
- TICK is ignored while RST=1.
- A sample taken on edge N updates the FSMs, flags, counters, MODE and FAULT on that same edge. MODE_STB is high during cycle N+1 only.
- Consecutive TICKs on back-to-back cycles are legal. Each one is processed, and MODE_STB pulses once per TICK.
- TICK=0: all state holds and the bulb inputs are don't-care.
- LEFT is first reported on the sample that completes the first left ramp, i.e. the 5th sample of 000,001,011,111,000.
- Counter wrap does not occur; CYC saturates at 2^CNT_W-1 and further ramps are not counted.

## Configuration
- TBIRD_MON_SKEW_CHECK_EN defined:
  - On any sample where both TURN flags are 1 after the update, BULB_L must equal BULB_R.
  - A mismatch forces both sides to FLT, FAULT=1, FAULT_SIDE=11.
- Not defined: no cross-side comparison. Hazard decode depends only on both TURN flags.

## Test plan
- Reset: RST=1 mid-ramp -> all outputs 0 immediately, and MODE=0 on the first TICK after release with both sides 000.
- Left turn: left samples 000,001,011,111,000 with right at 000 -> MODE=1 and CYC_L=1 after the 5th sample; MODE_STB pulses once per sample.
- Brake: both sides 111 for 2 samples -> MODE=3. Then 4 samples of 000 on both sides -> MODE=0.
- Illegal pattern: left 010 -> MODE=7, FAULT=1, FAULT_SIDE=10. A subsequent legal left ramp leaves MODE=7 until RST.
- Turn timeout and turn+brake:
  - after one left ramp, IDLE_TO=4 idle samples -> MODE=0;
  - left ramping with right held at 111 -> MODE=5.
- Skew check: both sides ramp with a one-sample offset, each having already completed one ramp -> FAULT=1, FAULT_SIDE=11 with TBIRD_MON_SKEW_CHECK_EN defined; without it, MODE=4 and FAULT=0.
